bpsk_carrier_dac_fmt: RTL and testbench
=======================================

Name: bpsk_carrier_dac_fmt

Overview:
Streaming BPSK carrier sample generator and DAC formatter.
- Accepts one symbol bit per handshake.
- For each symbol, sweeps an external cosine LUT for PERIODS_PER_SYMBOL carrier periods and inverts the carrier for bit 1.
- Rounds and saturates each sample from IN_WIDTH fixed-point to an OUT_WIDTH DAC word.
- Sits between the TX symbol source and the DAC interface, with valid/ready backpressure on both sides.

Parameters:
SAMPLES_PER_PERIOD, 16, LUT entries per carrier period; power of two, >=4
PERIODS_PER_SYMBOL, 4, carrier periods per symbol; >=1
IN_WIDTH, 16, signed LUT sample width (Q1.IN_WIDTH-2, +1.0 = 2^(IN_WIDTH-2))
OUT_WIDTH, 12, DAC word width; must be < IN_WIDTH

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
sym_valid  in  1  symbol bit available
sym_ready  out  1  block accepts a symbol this cycle
sym_bit  in  1  BPSK bit; 0 = carrier as-is, 1 = carrier negated
lut_addr  out  $clog2(SAMPLES_PER_PERIOD)  combinational LUT read address
lut_data  in  IN_WIDTH  signed LUT sample, valid in the same cycle as lut_addr
dac_valid  out  1  dac_data holds a sample
dac_ready  in  1  DAC consumes the sample this cycle
dac_data  out  OUT_WIDTH  formatted sample
sym_done  out  1  one-cycle pulse when the last sample of a symbol is loaded into dac_data

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE, sample counter = 0, flip = 0
  - dac_valid = 0, dac_data = 0 (0x800 if OFFSET_BINARY_EN), sym_done = 0
- FSM states: IDLE, RUN.
- Total samples per symbol: N = SAMPLES_PER_PERIOD*PERIODS_PER_SYMBOL.
- Counter and address:
  - cnt counts 0..N-1.
  - lut_addr = cnt mod SAMPLES_PER_PERIOD, driven combinationally from cnt (0 in IDLE).
- load = (state==RUN) && (!dac_valid || dac_ready).
- On load:
  - dac_data <= fmt(lut_data, flip); dac_valid <= 1; cnt increments.
  - At cnt==N-1: cnt wraps to 0 and sym_done pulses.
- When dac_valid && dac_ready && !load: dac_valid <= 0.
- Output stall: dac_data and dac_valid hold while dac_valid && !dac_ready.
- Latency: LUT address to dac_data is exactly 1 cycle; one sample per cycle sustained under continuous dac_ready.
- sym_ready:
  - In IDLE: sym_ready = 1.
  - In RUN: sym_ready = load && cnt==N-1, which allows back-to-back symbols with no bubble.
- Symbol accept (sym_valid && sym_ready):
  - flip <= sym_bit; state <= RUN.
  - When accepted at a symbol boundary, cnt restarts at 0 and the new flip applies from the next load.
- If the last sample loads with no symbol accepted: state <= IDLE; dac_valid drains normally.
- fmt(x, f), with S = IN_WIDTH-OUT_WIDTH:
  - y = f ? -x : x, computed in IN_WIDTH+1 bits so that -(-2^(IN_WIDTH-1)) = +2^(IN_WIDTH-1) is exact.
  - r = (y + 2^(S-1)) >>> S: round half toward +inf, arithmetic shift.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- sym_valid while RUN and not at a boundary: ignored; sym_bit is not sampled.
- Reset asserted mid-symbol: the in-flight sample is discarded and the block returns to IDLE with no further dac_valid until a new symbol is accepted.

Optional Feature:
- Macro: OFFSET_BINARY_EN.
- Defined: dac_data MSB is inverted after saturation (offset binary; 0 maps to 0x800 at OUT_WIDTH=12); the reset value becomes the midscale code.
- Undefined: dac_data is two's complement; reset value 0.
- Rounding, saturation and timing are identical in both builds.

Test Plan:
- Single symbol, bit 0, lut_data constant 16384, dac_ready=1 -> 64 samples of 0x400, lut_addr cycles 0..15 four times, one sym_done on the 64th load, sym_ready=1 one cycle later, then dac_valid=0.
- Back-to-back bits 0,1 with sym_valid held, lut_data=16384 -> 64x 0x400 then 64x 0xC00 with no dac_valid gap; sym_ready is high only in the cycle of the 64th load.
- Rounding and saturation, bit 0 then bit 1:
  - bit 0: lut_data 8 -> 1; 7 -> 0; -8 -> 0; -9 -> -1 (0xFFF).
  - bit 1: lut_data -32768 -> 2047 (0x7FF, saturated).
- Backpressure: dac_ready low 5 cycles after the 3rd sample -> dac_data/dac_valid/lut_addr frozen; the sequence resumes with no lost or duplicated samples.
- Reset asserted at sample 20 of a symbol -> dac_valid=0 and sym_ready=1 asynchronously; after release, a new bit-1 symbol starts at lut_addr 0.
- With OFFSET_BINARY_EN: lut_data 16384 bit 0 -> 0xC00; bit 1 -> 0x400; dac_data after reset = 0x800.

Source files
------------

// File: rtl/bpsk_carrier_dac_fmt.sv
// BPSK carrier generator + DAC formatter: LUT addr -> dac_data in 1 cycle, holds output while dac_ready low.
// Define OFFSET_BINARY_EN for offset-binary DAC codes (MSB inverted, midscale reset value).
module bpsk_carrier_dac_fmt #(
  parameter int SAMPLES_PER_PERIOD = 16,
  parameter int PERIODS_PER_SYMBOL = 4,
  parameter int IN_WIDTH           = 16,
  parameter int OUT_WIDTH          = 12
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sym_valid,
  output logic                                  sym_ready,
  input  logic                                  sym_bit,
  output logic [$clog2(SAMPLES_PER_PERIOD)-1:0] lut_addr,
  input  logic signed [IN_WIDTH-1:0]            lut_data,
  output logic                                  dac_valid,
  input  logic                                  dac_ready,
  output logic [OUT_WIDTH-1:0]                  dac_data,
  output logic                                  sym_done
);

  localparam int AW = $clog2(SAMPLES_PER_PERIOD);
  localparam int N  = SAMPLES_PER_PERIOD * PERIODS_PER_SYMBOL;
  localparam int CW = $clog2(N);
  localparam int S  = IN_WIDTH - OUT_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic signed [IN_WIDTH:0]  RND     = (IN_WIDTH+1)'(1) << (S - 1);
  localparam logic signed [OUT_WIDTH:0] SAT_MAX = (OUT_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [OUT_WIDTH:0] SAT_MIN = (OUT_WIDTH+1)'(-(1 << (OUT_WIDTH - 1)));
`ifdef OFFSET_BINARY_EN
  localparam logic [OUT_WIDTH-1:0] MSB_FLIP = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`else
  localparam logic [OUT_WIDTH-1:0] MSB_FLIP = '0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic            flip;
  logic            load, last, accept;

  // One extra bit so negating the most negative input stays exact.
  function automatic logic [OUT_WIDTH-1:0] fmt(input logic signed [IN_WIDTH-1:0] x,
                                               input logic f);
    logic signed [IN_WIDTH:0]  y;
    logic signed [IN_WIDTH:0]  sum;
    logic signed [OUT_WIDTH:0] r;
    y   = f ? -((IN_WIDTH+1)'(x)) : (IN_WIDTH+1)'(x);
    sum = y + RND;
    r   = sum[IN_WIDTH:S];
    if (r > SAT_MAX)      r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[OUT_WIDTH-1:0] ^ MSB_FLIP;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = RUN;
      RUN:  if (load && last && !accept) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    last      = (cnt == LAST);
    load      = (state == RUN) && (!dac_valid || dac_ready);
    sym_ready = (state == IDLE) || (load && last);
    accept    = sym_valid && sym_ready;
    lut_addr  = (state == RUN) ? cnt[AW-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      flip      <= 1'b0;
      dac_valid <= 1'b0;
      dac_data  <= MSB_FLIP;
      sym_done  <= 1'b0;
    end else begin
      sym_done <= load && last;
      if (load) begin
        dac_data  <= fmt(lut_data, flip);
        dac_valid <= 1'b1;
        cnt       <= last ? '0 : cnt + 1'b1;
      end else if (dac_valid && dac_ready) begin
        dac_valid <= 1'b0;
      end
      // New polarity takes effect from the load after the accept.
      if (accept) flip <= sym_bit;
    end
  end

endmodule

// File: tb/tb_bpsk_carrier_dac_fmt.sv
// Directed bench for bpsk_carrier_dac_fmt: scoreboard of expected DAC words, checked on each consumed sample.
module tb_bpsk_carrier_dac_fmt;
  localparam int SPP = 16;
  localparam int NS  = 64;
`ifdef OFFSET_BINARY_EN
  localparam logic [11:0] MID = 12'h800;
`else
  localparam logic [11:0] MID = 12'h000;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic sym_valid = 1'b0, sym_bit = 1'b0, dac_ready = 1'b1;
  logic sym_ready, dac_valid, sym_done;
  logic [3:0] lut_addr;
  logic signed [15:0] lut_data;
  logic [11:0] dac_data;
  logic signed [15:0] lut_mem [16];

  int n_checks = 0, n_fail = 0, n_pop = 0, done_cnt = 0, gaps = 0;
  bit active = 1'b0;
  logic [11:0] q[$];

  assign lut_data = lut_mem[lut_addr];
  always #5 clk = ~clk;

  bpsk_carrier_dac_fmt #(.SAMPLES_PER_PERIOD(16), .PERIODS_PER_SYMBOL(4),
                         .IN_WIDTH(16), .OUT_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_bit(sym_bit),
    .lut_addr(lut_addr), .lut_data(lut_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .dac_data(dac_data), .sym_done(sym_done));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: negate, round half up by 16, saturate to 12 bits.
  function automatic logic [11:0] model(input int x, input bit b);
    int y, r;
    logic [11:0] o;
    y = b ? -x : x;
    r = $rtoi($floor((real'(y) + 8.0) / 16.0));
    if (r > 2047) r = 2047;
    else if (r < -2048) r = -2048;
    o = r[11:0];
    return o ^ MID;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (sym_done) done_cnt++;
      if (dac_valid) active = 1'b1;
      else if (active && dac_ready) gaps++;
      if (dac_valid && dac_ready) begin
        n_checks++;
        assert (q.size() != 0) else begin
          n_fail++;
          $error("FAIL spurious_sample: observed 0x%0h with no expected entry", dac_data);
        end
        if (q.size() != 0) check("dac_data", {20'b0, dac_data}, {20'b0, q.pop_front()});
        n_pop++;
        if (q.size() == 0) active = 1'b0;
      end
    end
  end

  task automatic send_sym(input bit b, output int waited);
    waited = 0;
    sym_valid = 1'b1;
    sym_bit = b;
    do begin
      @(negedge clk);
      waited++;
    end while (!sym_ready && waited < 300);
    check("sym_accept", {31'b0, sym_ready}, 32'd1);
    for (int i = 0; i < NS; i++) q.push_back(model(int'(lut_mem[i % SPP]), b));
    @(posedge clk); #1;
    sym_valid = 1'b0;
    sym_bit = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || dac_valid) && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    check("drain_queue", q.size(), 32'd0);
    check("drain_dac_valid", {31'b0, dac_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_pops(input int target);
    int k = 0;
    while (n_pop < target && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("pop_wait", {31'b0, (n_pop >= target)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int i = 0; i < SPP; i++) lut_mem[i] = 16'sd16384;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dac_valid", {31'b0, dac_valid}, 32'd0);
    check("rst_dac_data", {20'b0, dac_data}, {20'b0, MID});
    check("rst_sym_done", {31'b0, sym_done}, 32'd0);
    check("rst_sym_ready", {31'b0, sym_ready}, 32'd1);
    check("rst_lut_addr", {28'b0, lut_addr}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_dac_valid", {31'b0, dac_valid}, 32'd0);

    // Single symbol, constant carrier.
    send_sym(1'b0, w);
    check("idle_accept_wait", w, 32'd1);
    drain();
    check("single_sym_done", done_cnt, 32'd1);
    check("single_sym_ready_after", {31'b0, sym_ready}, 32'd1);

    // Back-to-back symbols, no bubble.
    gaps = 0;
    send_sym(1'b0, w);
    send_sym(1'b1, w);
    check("b2b_ready_at_64th_load", w, 32'd64);
    drain();
    check("b2b_gaps", gaps, 32'd0);
    check("b2b_sym_done", done_cnt, 32'd3);

    // Rounding and saturation.
    for (int i = 0; i < SPP; i++) lut_mem[i] = 16'(i * 100 - 700);
    lut_mem[0] = 16'sd8;  lut_mem[1] = 16'sd7;  lut_mem[2] = -16'sd8;
    lut_mem[3] = -16'sd9; lut_mem[4] = -16'sd32768; lut_mem[5] = 16'sd32767;
    lut_mem[6] = -16'sd1; lut_mem[7] = 16'sd24;
    send_sym(1'b0, w);
    send_sym(1'b1, w);
    drain();
    check("round_sym_done", done_cnt, 32'd5);

    // Backpressure: stall 5 cycles after the 3rd sample is consumed.
    for (int i = 0; i < SPP; i++) lut_mem[i] = 16'(i * 2048 - 16384);
    send_sym(1'b0, w);
    wait_pops(n_pop + 3);
    dac_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_dac_valid", {31'b0, dac_valid}, 32'd1);
      check("stall_dac_data", {20'b0, dac_data}, {20'b0, model(int'(lut_mem[3]), 1'b0)});
      check("stall_lut_addr", {28'b0, lut_addr}, 32'd4);
    end
    @(posedge clk); #1;
    dac_ready = 1'b1;
    drain();
    check("bp_sym_done", done_cnt, 32'd6);

    // Reset mid-symbol.
    send_sym(1'b0, w);
    wait_pops(n_pop + 20);
    rst = 1'b1;
    #1;
    check("arst_dac_valid", {31'b0, dac_valid}, 32'd0);
    check("arst_sym_ready", {31'b0, sym_ready}, 32'd1);
    check("arst_dac_data", {20'b0, dac_data}, {20'b0, MID});
    q.delete();
    active = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("post_rst_dac_valid", {31'b0, dac_valid}, 32'd0);
    end
    for (int i = 0; i < SPP; i++) lut_mem[i] = 16'(i * 1500 - 12000);
    @(posedge clk); #1;
    send_sym(1'b1, w);
    check("post_rst_accept_wait", w, 32'd1);
    drain();
    check("final_sym_done", done_cnt, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
